// File: rtl/snn_train_test_classify.sv
// snn_train_test_classify: rate-coded LIF spiking classifier core with weight load, supervised training and inference
// Ports: i_clk, i_rst_n (async, active-low); i_start_main/o_ready start handshake; i_train_test_classify mode and
//   i_test_label captured at start; i_image_in/i_weight_in words qualified by i_valid_image during LOAD;
//   o_start_core_img and o_valid_all one-cycle pulses; o_image_label winning neuron or 0xFF.
module snn_train_test_classify #(
  parameter int M = 784, N = 8, W = 24, IM_WID = 28, IM_HEI = 28,
  parameter int D = 614, TH = 8192, REF = 30, PRES = 0, PMIN = -204800,
  parameter int WMAX = 6144, WMIN = -4915, TSTEP = 16, LR = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_main,
  input  logic [1:0]  i_train_test_classify,
  input  logic [7:0]  i_test_label,
  input  logic [31:0] i_image_in,
  input  logic        i_valid_image,
  input  logic [31:0] i_weight_in,
  output logic        o_ready,
  output logic [7:0]  o_image_label,
  output logic        o_start_core_img,
  output logic        o_valid_all
);
  localparam int AW = $clog2(M), IW = $clog2(M + 1), JW = N > 1 ? $clog2(N) : 1;
  localparam int TW = $clog2(TSTEP + 1), RW = $clog2(REF + 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, LEARN, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_mode;
  logic [7:0] r_lbl, r_label, w_arg;
  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic [TW-1:0] r_t;
  logic r_start, r_valid;
  logic [31:0] r_img [M/4];
  logic signed [W-1:0] r_w [N][M];
  logic [M-1:0] r_spk;
  logic signed [31:0] r_p [N], w_acc [N], w_fire [N];
  logic [RW-1:0] r_ref [N];
  logic [TW-1:0] r_cnt [N], w_best;
  logic [N-1:0] w_fspk;
  logic [AW-1:0] w_ii;
  logic [31:0] w_word;
  logic [7:0] w_pix;
  logic w_spk, w_fstep, w_li, w_last, w_go_run, w_learn, w_unused;
  logic signed [W-1:0] w_wold, w_wnew;
  logic signed [31:0] w_upd;
  function automatic logic signed [31:0] sat(input logic signed [32:0] v);
    sat = (v[32] ^ v[31]) ? {v[32], {31{~v[32]}}} : v[31:0];
  endfunction
  assign w_unused = ^{i_weight_in[31:W], IM_WID[0], IM_HEI[0]};
  assign w_ii = r_i[AW-1:0];
  assign w_word = r_img[w_ii[AW-1:2]];
  assign w_pix = w_word[{w_ii[1:0], 3'b000} +: 8];
  // rate code: pixel spikes when floor(p*t/256) steps up between t and t+1
  assign w_spk = ((32'(w_pix) * (32'(r_t) + 1)) >> 8) != ((32'(w_pix) * 32'(r_t)) >> 8);
  assign w_fstep = r_i == IW'(M);
  assign w_li = r_i == (r_mode == 2'd0 ? IW'(M - 1) : IW'(M / 4 - 1));
  assign w_last = r_state == LOAD && i_valid_image && w_li && (r_mode != 2'd0 || r_j == JW'(N - 1));
  assign w_go_run = w_last && r_mode != 2'd0;
  assign w_learn = r_state == LEARN && r_lbl < 8'(N);
  assign w_wold = r_w[r_lbl[JW-1:0]][w_ii];
  assign w_upd = 32'(w_wold) + (r_spk[w_ii] ? 32'(LR) : -32'(LR));
  assign w_wnew = w_upd > WMAX ? W'(WMAX) : w_upd < WMIN ? W'(WMIN) : W'(w_upd);
  for (genvar g = 0; g < N; g++) begin : g_n
    logic signed [32:0] w_sum, w_dec;
    logic signed [31:0] w_pre;
    assign w_sum = 33'(r_p[g]) + 33'(r_w[g][w_ii]);
    assign w_dec = 33'(r_p[g]) - 33'(D);
    assign w_acc[g] = w_spk && r_ref[g] == '0 ? sat(w_sum) : r_p[g];
    assign w_fspk[g] = r_ref[g] == '0 && r_p[g] >= TH;
    assign w_pre = r_ref[g] != '0 ? r_p[g] : w_fspk[g] ? PRES :
                   r_p[g] > PRES ? (sat(w_dec) < PRES ? PRES : sat(w_dec)) : r_p[g];
    assign w_fire[g] = w_pre < PMIN ? PMIN : w_pre;
  end
  // strict > keeps the lowest index on ties; no spikes leaves 0xFF
  always_comb begin
    w_arg = 8'hFF;
    w_best = '0;
    for (int k = 0; k < N; k++)
      if (r_cnt[k] > w_best) begin
        w_best = r_cnt[k];
        w_arg = 8'(k);
      end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start_main ? LOAD : IDLE;
      LOAD:    w_next = w_last ? (r_mode == 2'd0 ? DONE : RUN) : LOAD;
      RUN:     w_next = w_fstep && r_t == TW'(TSTEP - 1) ? (r_mode == 2'd1 ? LEARN : DONE) : RUN;
      LEARN:   w_next = r_i == IW'(M - 1) ? DONE : LEARN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= '0;
      r_lbl <= '0;
      r_label <= '0;
      r_i <= '0;
      r_j <= '0;
      r_t <= '0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_spk <= '0;
      for (int k = 0; k < N; k++) begin
        r_p[k] <= '0;
        r_ref[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      r_start <= w_last;
      r_valid <= r_state == DONE;
      if (r_state == DONE && r_mode != 2'd0) r_label <= w_arg;
      if (r_state == IDLE && i_start_main) begin
        r_mode <= i_train_test_classify;
        r_lbl <= i_test_label;
        r_i <= '0;
        r_j <= '0;
      end
      if (r_state == LOAD && i_valid_image) begin
        r_i <= w_li ? '0 : r_i + 1'b1;
        if (w_li) r_j <= r_j + 1'b1;
      end
      if (w_go_run) begin
        r_t <= '0;
        r_spk <= '0;
        for (int k = 0; k < N; k++) begin
          r_p[k] <= PRES;
          r_ref[k] <= '0;
          r_cnt[k] <= '0;
        end
      end
      if (r_state == RUN) begin
        r_i <= w_fstep ? '0 : r_i + 1'b1;
        if (w_fstep) r_t <= r_t + 1'b1;
        if (!w_fstep && w_spk) r_spk[w_ii] <= 1'b1;
        for (int k = 0; k < N; k++)
          if (w_fstep) begin
            r_p[k] <= w_fire[k];
            r_ref[k] <= r_ref[k] != '0 ? r_ref[k] - 1'b1 : w_fspk[k] ? RW'(REF) : '0;
            r_cnt[k] <= r_cnt[k] + TW'(w_fspk[k]);
          end else r_p[k] <= w_acc[k];
      end
      if (r_state == LEARN) r_i <= r_i + 1'b1;
    end
  end
  always_ff @(posedge i_clk)
    if (r_state == LOAD && i_valid_image && r_mode != 2'd0) r_img[r_i[AW-3:0]] <= i_image_in;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int j = 0; j < N; j++)
        for (int i = 0; i < M; i++) r_w[j][i] <= '0;
    end else if (r_state == LOAD && i_valid_image && r_mode == 2'd0) r_w[r_j][w_ii] <= i_weight_in[W-1:0];
    else if (w_learn) r_w[r_lbl[JW-1:0]][w_ii] <= w_wnew;
  assign o_ready = r_state == IDLE;
  assign o_image_label = r_label;
  assign o_start_core_img = r_start;
  assign o_valid_all = r_valid;
endmodule

// File: tb/tb_snn_train_test_classify.sv
// tb_snn_train_test_classify: directed self-checking bench for the SNN core on a reduced 16-pixel image
module tb_snn_train_test_classify;
  localparam int M = 16, N = 8, TSTEP = 16;
  localparam int LAT_RUN = TSTEP * (M + 1) + 1;
  localparam int LAT_TRAIN = TSTEP * (M + 1) + M + 1;
  logic clk = 1'b0, rst_n = 1'b0, start_main = 1'b0, valid_image = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] test_label = 8'd0;
  logic [31:0] image_in = '0, weight_in = '0;
  logic ready, start_core_img, valid_all;
  logic [7:0] image_label;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  snn_train_test_classify #(.M(M), .N(N), .IM_WID(4), .IM_HEI(4), .TSTEP(TSTEP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_main(start_main), .i_train_test_classify(mode),
    .i_test_label(test_label), .i_image_in(image_in), .i_valid_image(valid_image),
    .i_weight_in(weight_in), .o_ready(ready), .o_image_label(image_label),
    .o_start_core_img(start_core_img), .o_valid_all(valid_all)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // drives one job; weights for neurons w1/w2 are 8192 in mode 0; returns start_core_img after the
  // last word and cycles from that point to valid_all (-1 if it never came)
  task automatic run_job(input logic [1:0] md, input logic [7:0] lbl, input logic [7:0] pix,
                         input int w1, input int w2, output logic sc, output int lat);
    int nw;
    start_main = 1'b1;
    mode = md;
    test_label = lbl;
    step();
    start_main = 1'b0;
    nw = md == 2'd0 ? M * N : M / 4;
    for (int k = 0; k < nw; k++) begin
      if (md != 2'd0 && k % 2 == 1) begin
        valid_image = 1'b0;
        step();
      end
      valid_image = 1'b1;
      image_in = {4{pix}};
      weight_in = (k / M == w1 || k / M == w2) ? 32'd8192 : 32'd0;
      step();
    end
    valid_image = 1'b0;
    sc = start_core_img;
    lat = -1;
    for (int c = 1; c <= 3000; c++) begin
      step();
      if (valid_all) begin
        lat = c;
        break;
      end
    end
  endtask
  task automatic test_reset();
    #12;
    n_cmp += 4;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    if (image_label !== 8'h00) begin n_bad++; $display("FAIL reset_label got %h want 00", image_label); end
    if (valid_all !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_all); end
    if (start_core_img !== 1'b0) begin n_bad++; $display("FAIL reset_sc got %b want 0", start_core_img); end
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_load_classify();
    logic sc;
    int lat;
    run_job(2'd0, 8'd0, 8'd0, 3, 3, sc, lat);
    n_cmp += 3;
    if (sc !== 1'b1) begin n_bad++; $display("FAIL load_sc got %b want 1", sc); end
    if (lat !== 1) begin n_bad++; $display("FAIL load_lat got %0d want 1", lat); end
    if (image_label !== 8'h00) begin n_bad++; $display("FAIL load_label got %h want 00", image_label); end
    run_job(2'd2, 8'd0, 8'd255, -1, -1, sc, lat);
    n_cmp += 4;
    if (sc !== 1'b1) begin n_bad++; $display("FAIL cls3_sc got %b want 1", sc); end
    if (lat !== LAT_RUN) begin n_bad++; $display("FAIL cls3_lat got %0d want %0d", lat, LAT_RUN); end
    if (image_label !== 8'd3) begin n_bad++; $display("FAIL cls3_label got %h want 03", image_label); end
    if (ready !== 1'b1) begin n_bad++; $display("FAIL cls3_ready got %b want 1", ready); end
    step();
    n_cmp++;
    if (valid_all !== 1'b0) begin n_bad++; $display("FAIL cls3_pulse got %b want 0", valid_all); end
  endtask
  task automatic test_zero_image();
    logic sc;
    int lat;
    run_job(2'd3, 8'd0, 8'd0, -1, -1, sc, lat);
    n_cmp += 2;
    if (lat !== LAT_RUN) begin n_bad++; $display("FAIL zero_lat got %0d want %0d", lat, LAT_RUN); end
    if (image_label !== 8'hFF) begin n_bad++; $display("FAIL zero_label got %h want ff", image_label); end
  endtask
  task automatic test_tie();
    logic sc;
    int lat;
    run_job(2'd0, 8'd0, 8'd0, 2, 6, sc, lat);
    n_cmp++;
    if (image_label !== 8'hFF) begin n_bad++; $display("FAIL tie_load_label got %h want ff", image_label); end
    run_job(2'd2, 8'd0, 8'd255, -1, -1, sc, lat);
    n_cmp++;
    if (image_label !== 8'd2) begin n_bad++; $display("FAIL tie_label got %h want 02", image_label); end
  endtask
  task automatic test_train();
    logic sc;
    int lat;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_job(2'd1, 8'd5, 8'd255, -1, -1, sc, lat);
    n_cmp += 2;
    if (lat !== LAT_TRAIN) begin n_bad++; $display("FAIL train_lat got %0d want %0d", lat, LAT_TRAIN); end
    if (image_label !== 8'hFF) begin n_bad++; $display("FAIL train_label got %h want ff", image_label); end
    run_job(2'd2, 8'd0, 8'd255, -1, -1, sc, lat);
    n_cmp++;
    if (image_label !== 8'd5) begin n_bad++; $display("FAIL trained_label got %h want 05", image_label); end
    run_job(2'd1, 8'd9, 8'd255, -1, -1, sc, lat);
    n_cmp++;
    if (image_label !== 8'd5) begin n_bad++; $display("FAIL badlbl_train_label got %h want 05", image_label); end
    run_job(2'd2, 8'd0, 8'd255, -1, -1, sc, lat);
    n_cmp++;
    if (image_label !== 8'd5) begin n_bad++; $display("FAIL badlbl_cls_label got %h want 05", image_label); end
  endtask
  task automatic test_reset_mid_run();
    logic sc;
    int lat, seen;
    start_main = 1'b1;
    mode = 2'd2;
    step();
    start_main = 1'b0;
    for (int k = 0; k < M / 4; k++) begin
      valid_image = 1'b1;
      image_in = 32'hFFFF_FFFF;
      step();
    end
    valid_image = 1'b0;
    repeat (60) step();
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL midrun_busy got %b want 0", ready); end
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL midrun_ready got %b want 1", ready); end
    if (valid_all !== 1'b0) begin n_bad++; $display("FAIL midrun_valid got %b want 0", valid_all); end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < LAT_RUN + 20; c++) begin
      step();
      if (valid_all) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midrun_novalid got %0d want 0", seen); end
    run_job(2'd2, 8'd0, 8'd255, -1, -1, sc, lat);
    n_cmp += 2;
    if (lat !== LAT_RUN) begin n_bad++; $display("FAIL after_lat got %0d want %0d", lat, LAT_RUN); end
    if (image_label !== 8'hFF) begin n_bad++; $display("FAIL after_label got %h want ff", image_label); end
  endtask
  initial begin
    test_reset();
    test_load_classify();
    test_zero_image();
    test_tie();
    test_train();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snn_train_test_classify.md
# snn_train_test_classify

Top-level spiking-neural-network core for the image classifier. It accepts one 8-bit grayscale image as packed 32-bit words and rate-codes the pixels into spikes. The spikes drive N leaky integrate-and-fire neurons through an M×N signed weight array, and the core reports the neuron with the most spikes as the image label. The same block loads weights, trains them with a supervised rule, or runs inference, selected per image by a mode input.

## Interface
- M, 784: pixels per image (multiple of 4).
- N, 8: output neurons (≤ 255).
- W, 24: weight width, signed Q12.
- IM_WID, 28 / IM_HEI, 28: image geometry, informational; M = IM_WID*IM_HEI.
- D, 614: leak per time step, Q12.
- TH, 8192: firing threshold, Q12.
- REF, 30: refractory period in time steps.
- PRES, 0: rest potential.
- PMIN, -204800: membrane floor.
- WMAX, 6144 / WMIN, -4915: weight clip limits.
- TSTEP, 16: time steps per image.
- LR, 256: training step size.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_main  in  1  start pulse, sampled only while ready=1.
- train_test_classify  in  2  mode, captured at start: 0 = weight load, 1 = train, 2 and 3 = classify.
- test_label  in  8  supervision label, captured at start; used in mode 1.
- image_in  in  32  pixel word; bits [8k+7:8k] = pixel 4j+k for word j.
- valid_image  in  1  qualifies image_in or weight_in in LOAD.
- weight_in  in  32  weight word; [W-1:0] used, signed.
- ready  out  1  idle, can accept start_main.
- image_label  out  8  winning neuron index, or 0xFF if no neuron spiked.
- start_core_img  out  1  one-cycle pulse when the input transfer is complete.
- valid_all  out  1  one-cycle pulse when the job is done; image_label is valid from then on.

## Operation
- States: IDLE → LOAD → RUN → (LEARN if mode 1) → DONE → IDLE. Mode 0 goes LOAD → DONE.
- IDLE: ready=1. When start_main=1, capture mode and test_label and enter LOAD. ready=0 from the next cycle.
- LOAD, modes 1–3: each cycle with valid_image=1 stores one word (4 pixels). After M/4 words, pulse start_core_img and enter RUN.
- LOAD, mode 0: each valid word writes one weight in neuron-major order (w[0][0..M-1], w[1][0..M-1], …). After M*N words, pulse start_core_img and enter DONE. image_label is unchanged.
- RUN: on entry, clear potentials P_j = PRES, refractory counters, and spike counts. Then for t = 0..TSTEP-1:
  - Accumulate: M cycles, one pixel i per cycle. Pixel p spikes at step t iff floor(p*(t+1)/256) ≠ floor(p*t/256). On a spike, each non-refractory P_j += w[j][i].
  - Fire: 1 cycle. For each neuron in parallel:
    - If refractory, decrement its counter.
    - Else if P_j ≥ TH: spike, count_j++, P_j = PRES, counter = REF.
    - Else if P_j > PRES: P_j = max(P_j − D, PRES).
    - Then P_j = max(P_j, PMIN).
- P_j is 32-bit signed and saturates at the 32-bit limits.
- Label = argmax count_j, lowest index on ties, 0xFF if all counts are 0. It is registered to image_label on entry to DONE.
- LEARN (mode 1): M cycles. For each i, if pixel i spiked in any step, w[test_label][i] += LR, otherwise −= LR. Results are clipped to [WMIN, WMAX]. If test_label ≥ N, no update.
- DONE: pulse valid_all for 1 cycle and set ready=1 in the same cycle, then go to IDLE.
- Reset: outputs go to ready=1, image_label=0, start_core_img=0, valid_all=0. The weight array clears to 0. Reset mid-job aborts to IDLE.

## Timing
- start_main sampled at edge 0 → LOAD from edge 1. The first word can be accepted at edge 1.
- valid_image is ignored outside LOAD. start_main is ignored when ready=0.
- start_core_img is high in the cycle after the last word is accepted.
- RUN lasts TSTEP*(M+1) cycles (12560 at defaults). LEARN lasts M cycles.
- valid_all follows 1 cycle after RUN or LEARN ends; in mode 0, 1 cycle after start_core_img.
- Gaps in valid_image stall LOAD and do not lose words.

## Test plan
- Reset with rst=0 → ready=1, image_label=0x00, valid_all=0, start_core_img=0.
- Mode 0: load w[3][*]=8192, all other weights 0. Then mode 2 on an all-255 image → valid_all pulse, image_label=3.
- Mode 2 on an all-0 image → no spikes, image_label=0xFF, valid_all exactly TSTEP*(M+1)+1 cycles after start_core_img.
- From reset, mode 1 with test_label=5 on an all-255 image → w[5][*]=256 and other weights 0. Then mode 2 on the same image → image_label=5.
- Tie: w[2][*] = w[6][*] = 8192, mode 2 on an all-255 image → image_label=2.
- Assert rst mid-RUN → ready=1 immediately, no valid_all. A following mode 2 job completes normally.
